decode_hazard_ctrl: RTL and testbench

//   Issue/stall controller for the decode stage and register-bank write ports.

---
 rtl/decode_hazard_ctrl_pkg.sv | 12 +
 rtl/decode_hazard_ctrl_if.sv | 42 ++++
 rtl/decode_hazard_ctrl_sb_counter.sv | 34 +++
 rtl/decode_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// decode_pkg: shared sizes, fixed register addresses and the vector-port
// FSM state type for the decode hazard controller.
package decode_pkg;
  localparam int NREG  = 16;              // register count
  localparam int AW    = 4;               // register address width
  localparam int CNT_W = 2;               // in-flight write counter width
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0] REG_LR = 4'b1110;  // forced on port A by sel_A
  localparam logic [AW-1:0] REG_V  = 4'b1111;  // vector reg, forced on port B by sel_B

  typedef enum logic {V_IDLE, V_HOLD} vstate_t;
endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// decode_hazard_ctrl_if: decode request, scalar/vector writeback and
// scoreboard status signals of the decode hazard controller.
//   master : decode/writeback source (drives id_*, wb_*, wbv_valid/data)
//   slave  : the controller (drives stall/issue, bank enables, status)
interface decode_hazard_ctrl_if;
  import decode_pkg::*;

  logic          id_valid;
  logic [AW-1:0] id_rp;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rd;
  logic          id_sel_A;
  logic          id_sel_B;
  logic          id_use_a;
  logic          id_use_b;
  logic          id_wr_c;
  logic          id_wr_v;
  logic          wb_valid;
  logic [AW-1:0] wb_rg;
  logic          wbv_valid;
  logic [7:0]    wbv_data;
  logic          wbv_ready;
  logic          stall;
  logic          issue;
  logic          WE_C;
  logic          WE_V;
  logic [7:0]    DinV_8bit;
  logic [NREG-1:0] sb_busy;
  logic          sb_err;

  modport master (
    output id_valid, id_rp, id_rs, id_rd, id_sel_A, id_sel_B, id_use_a, id_use_b,
           id_wr_c, id_wr_v, wb_valid, wb_rg, wbv_valid, wbv_data,
    input  wbv_ready, stall, issue, WE_C, WE_V, DinV_8bit, sb_busy, sb_err
  );

  modport slave (
    input  id_valid, id_rp, id_rs, id_rd, id_sel_A, id_sel_B, id_use_a, id_use_b,
           id_wr_c, id_wr_v, wb_valid, wb_rg, wbv_valid, wbv_data,
    output wbv_ready, stall, issue, WE_C, WE_V, DinV_8bit, sb_busy, sb_err
  );
endinterface

// File: rtl/decode_hazard_ctrl_sb_counter.sv
// sb_counter: one scoreboard entry. Up/down counter of in-flight writes.
//   clk, rst_n : clock, async active-low clear
//   inc_i      : writes issued this cycle (0..2)
//   dec_i      : one write retired this cycle
//   cnt_o      : current count
//   udf_o      : pulse, retire seen with nothing in flight (count held at 0)
module sb_counter
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             udf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    udf_o = 1'b0;
    // Net change is applied, so an issue and a retire in one cycle cancel.
    if (dec_i && inc_i == 2'd0 && cnt_q == '0)
      udf_o = 1'b1;
    else
      cnt_d = cnt_q + CNT_W'(inc_i) - CNT_W'(dec_i);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode issue/stall control plus bank write-port
// arbitration.
//   clk, rst_n : clock, async active-low reset
//   bus        : decode_hazard_ctrl_if.slave
//     id_*      decoded instruction; stall/issue returned combinationally
//     wb_*      scalar writeback -> WE_C, retires cnt[wb_rg]
//     wbv_*     vector result (valid/ready) -> WE_V/DinV_8bit, retires cnt[REG_V]
//     sb_busy   per-register "writes in flight", sb_err sticky underflow
// Scalar writeback always wins reg 15; a colliding vector byte waits in a
// one-entry hold register and the vector source is back-pressured meanwhile.
module decode_hazard_ctrl
  import decode_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  decode_hazard_ctrl_if.slave bus
);
  localparam int SW = CNT_W + 2;  // headroom for cnt + 2 in the full check

  logic [AW-1:0]                addr_a, addr_b;
  logic [NREG-1:0][CNT_W-1:0]   cnt;
  logic [NREG-1:0][1:0]         req_inc, inc;
  logic [NREG-1:0]              dec, udf, full;
  logic                         hazard, issue_w, we_c, we_v, coll, ready;
  logic [7:0]                   dinv;
  logic                         sb_err_q;
  vstate_t                      vstate_q, vstate_d;
  logic [7:0]                   hold_q, hold_d;

  assign addr_a = bus.id_sel_A ? REG_LR : bus.id_rp;
  assign addr_b = bus.id_sel_B ? REG_V  : bus.id_rs;

  // Per-register increment the instruction would apply. rd==REG_V with both
  // write kinds adds two to the same counter.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      req_inc[i] = 2'(bus.id_wr_c && bus.id_rd == AW'(i))
                 + 2'(bus.id_wr_v && REG_V == AW'(i));
      full[i]    = (SW'(cnt[i]) + SW'(req_inc[i])) > SW'(CNT_MAX);
    end
  end

  // Hazards use the registered counts only: a retire takes effect next cycle.
  assign hazard  = (bus.id_use_a && cnt[addr_a] != '0)
                 | (bus.id_use_b && cnt[addr_b] != '0)
                 | (|full);
  assign issue_w = rst_n && bus.id_valid && !hazard;

  assign we_c = rst_n && bus.wb_valid;
  assign coll = bus.wb_valid && bus.wb_rg == REG_V;

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      inc[i] = issue_w ? req_inc[i] : 2'd0;
      dec[i] = (we_c && bus.wb_rg == AW'(i)) || (we_v && REG_V == AW'(i));
    end
  end

  sb_counter u_cnt [NREG-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (inc),
    .dec_i (dec),
    .cnt_o (cnt),
    .udf_o (udf)
  );

  // Vector write-port FSM
  always_comb begin
    vstate_d = vstate_q;
    hold_d   = hold_q;
    we_v     = 1'b0;
    dinv     = 8'h00;
    ready    = 1'b0;
    case (vstate_q)
      V_IDLE: begin
        ready = 1'b1;
        if (bus.wbv_valid) begin
          if (!coll) begin
            we_v = 1'b1;
            dinv = bus.wbv_data;
          end else begin
            hold_d   = bus.wbv_data;
            vstate_d = V_HOLD;
          end
        end
      end
      V_HOLD: begin
        if (!coll) begin
          we_v     = 1'b1;
          dinv     = hold_q;
          vstate_d = V_IDLE;
        end
      end
      default: vstate_d = V_IDLE;
    endcase
    // Outputs stay quiet while reset is held.
    if (!rst_n) begin
      we_v  = 1'b0;
      dinv  = 8'h00;
      ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vstate_q <= V_IDLE;
      hold_q   <= 8'h00;
      sb_err_q <= 1'b0;
    end else begin
      vstate_q <= vstate_d;
      hold_q   <= hold_d;
      if (|udf) sb_err_q <= 1'b1;
    end

  always_comb begin
    for (int i = 0; i < NREG; i++) bus.sb_busy[i] = cnt[i] != '0;
  end

  assign bus.stall     = rst_n && bus.id_valid && hazard;
  assign bus.issue     = issue_w;
  assign bus.WE_C      = we_c;
  assign bus.WE_V      = we_v;
  assign bus.DinV_8bit = dinv;
  assign bus.wbv_ready = ready;
  assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl_if bus();

  decode_hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rp = 0; bus.id_rs = 0; bus.id_rd = 0;
    bus.id_sel_A = 0; bus.id_sel_B = 0; bus.id_use_a = 0; bus.id_use_b = 0;
    bus.id_wr_c = 0; bus.id_wr_v = 0;
    bus.wb_valid = 0; bus.wb_rg = 0; bus.wbv_valid = 0; bus.wbv_data = 0;
  endtask

  task automatic id(input logic [3:0] rp, input logic [3:0] rs, input logic [3:0] rd,
                    input logic sa, input logic sb, input logic ua, input logic ub,
                    input logic wc, input logic wv);
    bus.id_valid = 1; bus.id_rp = rp; bus.id_rs = rs; bus.id_rd = rd;
    bus.id_sel_A = sa; bus.id_sel_B = sb; bus.id_use_a = ua; bus.id_use_b = ub;
    bus.id_wr_c = wc; bus.id_wr_v = wv;
  endtask

  task automatic wb(input logic v, input logic [3:0] rg);
    bus.wb_valid = v; bus.wb_rg = rg;
  endtask

  task automatic wbv(input logic v, input logic [7:0] d);
    bus.wbv_valid = v; bus.wbv_data = d;
  endtask

  initial begin
    // Reset with every request active: all outputs must read 0.
    rst_n = 0;
    idle();
    id(4'd1, 4'd2, 4'd3, 0, 0, 1, 1, 1, 1);
    wb(1, 4'd15); wbv(1, 8'h11);
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_issue", bus.issue, 0);
    chk("rst_wec", bus.WE_C, 0);
    chk("rst_wev", bus.WE_V, 0);
    chk("rst_ready", bus.wbv_ready, 0);
    chk("rst_busy", bus.sb_busy, 0);
    chk("rst_err", bus.sb_err, 0);
    @(negedge clk); rst_n = 1; idle();

    // 1: RAW on r3, cleared the cycle after the retire
    @(negedge clk); id(0, 0, 3, 0, 0, 0, 0, 1, 0); #1;
    chk("t1_issue", bus.issue, 1);
    chk("t1_nostall", bus.stall, 0);
    @(negedge clk); id(3, 0, 0, 0, 0, 1, 0, 0, 0); #1;
    chk("t1_stall", bus.stall, 1);
    chk("t1_noissue", bus.issue, 0);
    chk("t1_busy", bus.sb_busy, 16'h0008);
    @(negedge clk); wb(1, 3); #1;
    chk("t1_nobypass", bus.stall, 1);
    chk("t1_wec", bus.WE_C, 1);
    @(negedge clk); wb(0, 0); #1;
    chk("t1_released", bus.issue, 1);
    chk("t1_busy0", bus.sb_busy, 0);

    // 2: sel_A redirects port A to r14
    @(negedge clk); id(0, 0, 14, 0, 0, 0, 0, 1, 0); #1;
    chk("t2_iss14", bus.issue, 1);
    @(negedge clk); id(0, 0, 5, 0, 0, 0, 0, 1, 0); #1;
    chk("t2_iss5", bus.issue, 1);
    @(negedge clk); id(5, 0, 0, 1, 0, 1, 0, 0, 0); #1;
    chk("t2_selA_stall", bus.stall, 1);
    chk("t2_busy", bus.sb_busy, 16'h4020);
    @(negedge clk); id(5, 0, 0, 0, 0, 1, 0, 0, 0); wb(1, 14); #1;
    chk("t2_raw5_stall", bus.stall, 1);
    @(negedge clk); id(5, 0, 0, 1, 0, 1, 0, 0, 0); wb(0, 0); #1;
    chk("t2_selA_issue", bus.issue, 1);
    chk("t2_busy5", bus.sb_busy, 16'h0020);
    @(negedge clk); idle(); wb(1, 5);

    // 3: counter saturation on r7
    @(negedge clk); idle(); id(0, 0, 7, 0, 0, 0, 0, 1, 0); #1;
    chk("t3_clean", bus.sb_busy, 0);
    chk("t3_iss1", bus.issue, 1);
    @(negedge clk); #1; chk("t3_iss2", bus.issue, 1);
    @(negedge clk); #1; chk("t3_iss3", bus.issue, 1);
    @(negedge clk); wb(1, 7); #1;
    chk("t3_full_stall", bus.stall, 1);
    chk("t3_busy", bus.sb_busy, 16'h0080);
    @(negedge clk); wb(0, 0); #1;
    chk("t3_after_retire", bus.issue, 1);
    @(negedge clk); idle(); wb(1, 7);
    @(negedge clk); wb(1, 7);
    @(negedge clk); wb(1, 7);

    // r15 preload; rd=15 with both writes needs two slots
    @(negedge clk); idle(); id(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    chk("t3_clean2", bus.sb_busy, 0);
    chk("pv_iss1", bus.issue, 1);
    @(negedge clk); #1; chk("pv_iss2", bus.issue, 1);
    @(negedge clk); id(0, 0, 15, 0, 0, 0, 0, 1, 1); #1;
    chk("pv_plus2_stall", bus.stall, 1);
    chk("pv_busy", bus.sb_busy, 16'h8000);
    @(negedge clk); id(0, 0, 0, 0, 1, 0, 1, 0, 0); #1;
    chk("pv_selB_stall", bus.stall, 1);

    // 4: vector collision -> held one cycle
    @(negedge clk); idle(); wb(1, 15); wbv(1, 8'hA5); #1;
    chk("t4_wev0", bus.WE_V, 0);
    chk("t4_ready1", bus.wbv_ready, 1);
    chk("t4_wec", bus.WE_C, 1);
    @(negedge clk); idle(); #1;
    chk("t4_drain_wev", bus.WE_V, 1);
    chk("t4_drain_data", bus.DinV_8bit, 8'hA5);
    chk("t4_drain_ready", bus.wbv_ready, 0);
    @(negedge clk); #1;
    chk("t4_ready_back", bus.wbv_ready, 1);
    chk("t4_wev_off", bus.WE_V, 0);
    chk("t4_busy0", bus.sb_busy, 0);
    chk("t4_noerr", bus.sb_err, 0);

    // 5: same-cycle issue+retire nets out; underflow sets sb_err
    @(negedge clk); id(0, 0, 2, 0, 0, 0, 0, 1, 0); #1;
    chk("t5_iss", bus.issue, 1);
    @(negedge clk); wb(1, 2); #1;
    chk("t5_iss_ret", bus.issue, 1);
    @(negedge clk); idle(); wb(1, 2); #1;
    chk("t5_busy2", bus.sb_busy, 16'h0004);
    @(negedge clk); wb(1, 9); #1;
    chk("t5_busy_clear", bus.sb_busy, 0);
    @(negedge clk); wb(0, 0); #1;
    chk("t5_err", bus.sb_err, 1);
    chk("t5_busy0", bus.sb_busy, 0);
    @(negedge clk); wbv(1, 8'h3C); #1;
    chk("vd_wev", bus.WE_V, 1);
    chk("vd_data", bus.DinV_8bit, 8'h3C);
    chk("vd_ready", bus.wbv_ready, 1);

    // 6: reset while a byte is held
    @(negedge clk); idle(); id(0, 0, 4, 0, 0, 0, 0, 1, 0); wb(1, 15); wbv(1, 8'h5A); #1;
    chk("t6_iss", bus.issue, 1);
    chk("t6_wev0", bus.WE_V, 0);
    @(negedge clk); idle(); wb(1, 15); #1;
    chk("t6_hold_ready", bus.wbv_ready, 0);
    chk("t6_hold_wev", bus.WE_V, 0);
    chk("t6_busy4", bus.sb_busy, 16'h0010);
    @(negedge clk); rst_n = 0; id(4, 0, 0, 0, 0, 1, 0, 0, 0); #1;
    chk("t6_rst_wev", bus.WE_V, 0);
    chk("t6_rst_ready", bus.wbv_ready, 0);
    chk("t6_rst_stall", bus.stall, 0);
    chk("t6_rst_issue", bus.issue, 0);
    chk("t6_rst_busy", bus.sb_busy, 0);
    chk("t6_rst_err", bus.sb_err, 0);
    chk("t6_rst_wec", bus.WE_C, 0);
    @(negedge clk); rst_n = 1; wb(0, 0); #1;
    chk("t6_post_wev", bus.WE_V, 0);
    chk("t6_post_ready", bus.wbv_ready, 1);
    chk("t6_post_issue", bus.issue, 1);
    @(negedge clk); #1;
    chk("t6_post_wev2", bus.WE_V, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
